// File: rtl/trip_sequencer.sv
// Trip-level controller for the taxi meter: turns panel buttons and the red-light
// sensor into distance-counter controls, accumulates waiting time and flags trip end.
module trip_sequencer #(
    parameter int TICK_DIV = 50,
    parameter int WAIT_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              btn_start,
    input  logic              btn_stop,
    input  logic              btn_pause,
    input  logic              btn_up,
    input  logic              btn_down,
    input  logic              light_red,
    output logic              start,
    output logic              waitL,
    output logic              pause,
    output logic [1:0]        speedup,
    output logic              dist_clr,
    output logic [WAIT_W-1:0] wait_time,
    output logic              trip_done,
    output logic [1:0]        state
);

    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_WAIT  = 2'b10,
        S_PAUSE = 2'b11
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        speed_q, speed_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic              dist_clr_q, dist_clr_d;
    logic              trip_done_q, trip_done_d;

    // Bit order: down, up, pause, stop, start.
    logic [4:0] btn_vec;
    logic [4:0] btn_q;
    logic [4:0] btn_edge;
    logic       start_e, stop_e, pause_e, up_e, down_e;

    assign btn_vec  = {btn_down, btn_up, btn_pause, btn_stop, btn_start};
    assign btn_edge = btn_vec & ~btn_q;
    assign start_e  = btn_edge[0];
    assign stop_e   = btn_edge[1];
    assign pause_e  = btn_edge[2];
    assign up_e     = btn_edge[3];
    assign down_e   = btn_edge[4];

    // Edge history resets high so a button held through reset release is not a press.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_q       <= '1;
            state_q     <= S_IDLE;
            speed_q     <= 2'd0;
            wait_q      <= '0;
            div_q       <= '0;
            dist_clr_q  <= 1'b0;
            trip_done_q <= 1'b0;
        end else begin
            btn_q       <= btn_vec;
            state_q     <= state_d;
            speed_q     <= speed_d;
            wait_q      <= wait_d;
            div_q       <= div_d;
            dist_clr_q  <= dist_clr_d;
            trip_done_q <= trip_done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        speed_d     = speed_q;
        wait_d      = wait_q;
        div_d       = '0;
        dist_clr_d  = 1'b0;
        trip_done_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_e) begin
                    state_d    = S_RUN;
                    dist_clr_d = 1'b1;
                    speed_d    = 2'd0;
                    wait_d     = '0;
                end
            end
            S_RUN: begin
                if (stop_e) begin
                    state_d     = S_IDLE;
                    trip_done_d = 1'b1;
                    speed_d     = 2'd0;
                end else begin
                    if (pause_e) begin
                        state_d = S_PAUSE;
                    end else if (light_red) begin
                        state_d = S_WAIT;
                    end
                    if (up_e && !down_e && speed_q != 2'd3) begin
                        speed_d = speed_q + 2'd1;
                    end else if (down_e && !up_e && speed_q != 2'd0) begin
                        speed_d = speed_q - 2'd1;
                    end
                end
            end
            S_WAIT: begin
                if (stop_e) begin
                    state_d     = S_IDLE;
                    trip_done_d = 1'b1;
                    speed_d     = 2'd0;
                end else if (pause_e) begin
                    state_d = S_PAUSE;
                end else if (!light_red) begin
                    state_d = S_RUN;
                end
                // Divider only runs here; leaving WAIT lets it fall back to 0.
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (wait_q != '1) begin
                        wait_d = wait_q + 1'b1;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            S_PAUSE: begin
                if (stop_e) begin
                    state_d     = S_IDLE;
                    trip_done_d = 1'b1;
                    speed_d     = 2'd0;
                end else if (pause_e) begin
                    state_d = light_red ? S_WAIT : S_RUN;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign state     = state_q;
    assign start     = (state_q != S_IDLE);
    assign waitL     = (state_q == S_WAIT);
    assign pause     = (state_q == S_PAUSE);
    assign speedup   = speed_q;
    assign wait_time = wait_q;
    assign dist_clr  = dist_clr_q;
    assign trip_done = trip_done_q;

endmodule

// File: doc/trip_sequencer.md
# trip_sequencer

Trip-level controller for the taxi meter. It turns the driver's buttons and the red-light sensor into the `start`, `waitL`, `pause`, `speedup` and clear controls that sequence the distance counter. It also accumulates red-light waiting time for the fare logic and flags trip completion. It sits between the panel input synchronizers and the distance/fare datapath.

## Interface
- `TICK_DIV`, 50: clk cycles per wait-time unit (≥2).
- `WAIT_W`, 8: width of the wait-time accumulator.

- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high.
- `btn_start` in 1: trip start button, already synchronized to clk, level.
- `btn_stop` in 1: trip end button, synchronized, level.
- `btn_pause` in 1: pause toggle button, synchronized, level.
- `btn_up` in 1: speed-up button, synchronized, level.
- `btn_down` in 1: speed-down button, synchronized, level.
- `light_red` in 1: red-light sensor, synchronized, level.
- `start` out 1: trip active; drives distance counter start.
- `waitL` out 1: in WAIT state; drives distance counter waitL.
- `pause` out 1: in PAUSE state; drives distance counter pause.
- `speedup` out 2: speed level 0–3; drives distance counter speedup.
- `dist_clr` out 1: one-cycle clear pulse to the distance counter reset.
- `wait_time` out WAIT_W: accumulated wait units for the current trip.
- `trip_done` out 1: one-cycle pulse when a trip ends.
- `state` out 2: IDLE=00, RUN=01, WAIT=10, PAUSE=11.

## Operation
- Button edges are detected internally as `btn & ~btn_q`, with one `btn_q` register per button. All `btn_q` registers reset to 1, so a button held through reset release does not produce an edge.
- Edge priority within one cycle is stop > pause > start. `light_red` is level-sensitive.
- IDLE:
  - start edge → RUN, pulse `dist_clr`, set `speedup`=0, set `wait_time`=0.
  - Stop and pause edges are ignored.
- RUN:
  - stop edge → IDLE with `trip_done` pulse.
  - Otherwise, pause edge → PAUSE.
  - Otherwise, `light_red`=1 → WAIT.
- WAIT:
  - stop edge → IDLE with `trip_done` pulse.
  - Otherwise, pause edge → PAUSE.
  - Otherwise, `light_red`=0 → RUN.
- PAUSE:
  - stop edge → IDLE with `trip_done` pulse.
  - Otherwise, pause edge → WAIT if `light_red`=1, else RUN.
- Start edges outside IDLE are ignored. There is no restart mid-trip.
- Output decode:
  - `start`=1 in every state except IDLE.
  - `waitL`=1 only in WAIT.
  - `pause`=1 only in PAUSE.
- Speed level:
  - Changes only in RUN.
  - Up edge increments, saturating at 3. Down edge decrements, saturating at 0.
  - Simultaneous up and down edges: no change.
  - The value is held in WAIT and PAUSE, and forced to 0 on entering IDLE.
- Wait timer:
  - The divider counts 0..TICK_DIV-1 only while in WAIT and restarts from 0 on each WAIT entry.
  - `wait_time` increments when the divider wraps, saturating at all-ones.
  - `wait_time` accumulates across multiple WAIT visits. It is held in IDLE until the next trip start clears it.

## Timing
- Reset values:
  - `state`=IDLE.
  - `start`, `waitL`, `pause`, `dist_clr`, `trip_done` = 0.
  - `speedup`=0, `wait_time`=0, divider=0.
- All outputs are registered or decoded from registers. There is no combinational path from inputs to outputs.
- An edge sampled at posedge k takes effect at posedge k: the new state, `dist_clr`, `trip_done` and `speedup` are all visible after posedge k. Latency is one clock from the input rising.
- `dist_clr` is high for exactly the first RUN cycle, in which the distance counter stays 0. Counting begins on the next cycle.
- `trip_done` is high for exactly the first IDLE cycle after a stop.
- WAIT entered at posedge k: the first `wait_time` increment occurs at posedge k+TICK_DIV.
- Leaving WAIT mid-count discards the partial unit.
- `reset` asserted at any time forces reset values immediately. No `trip_done` pulse is generated.

## Test plan
- Reset, start edge: after 1 clock, `state`=01, `start`=1, `dist_clr`=1 for exactly 1 cycle. Distance counter reads 0 then increments by 1 per clock.
- RUN, three up edges then one down edge: `speedup` goes 1, 2, 3, 2. Four further up edges: `speedup` stays 3. Up and down in the same cycle: no change.
- RUN, `light_red`=1 for 120 clocks with TICK_DIV=50: `waitL`=1, `wait_time`=2, distance frozen. `light_red`=0 → RUN, `wait_time` held at 2.
- Pause edge during WAIT → PAUSE. Second pause edge with `light_red` still 1 → WAIT. Second pause edge with `light_red`=0 → RUN.
- Stop and pause edges in the same cycle from RUN → IDLE, `trip_done` 1-cycle pulse, `speedup`=0. `wait_time` holds until the next start edge, then reads 0.
- `reset` asserted mid-WAIT → all outputs 0 immediately. `btn_start` held high across reset release produces no start.
